// File: rtl/video_sig_gen_cfg.sv
// Video timing generator with programmable sync polarity, pixel-enable stall,
// new-line / new-frame pulses and a wrapping frame counter. All outputs are
// registered; the decode runs on the next position before it is registered.
module video_sig_gen_cfg #(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int H_FRONT_PORCH   = 110,
  parameter int H_SYNC_WIDTH    = 40,
  parameter int H_BACK_PORCH    = 220,
  parameter int ACTIVE_LINES    = 720,
  parameter int V_FRONT_PORCH   = 5,
  parameter int V_SYNC_WIDTH    = 5,
  parameter int V_BACK_PORCH    = 20,
  parameter bit H_SYNC_POL      = 1'b1,
  parameter bit V_SYNC_POL      = 1'b1,
  parameter int HCOUNT_WIDTH    = 11,
  parameter int VCOUNT_WIDTH    = 10,
  parameter int FC_WIDTH        = 6,
  parameter int FC_MAX          = 60
) (
  input  logic                    clk_pixel_in,
  input  logic                    rst_in,
  input  logic                    en_in,
  output logic [HCOUNT_WIDTH-1:0] hcount_out,
  output logic [VCOUNT_WIDTH-1:0] vcount_out,
  output logic                    hs_out,
  output logic                    vs_out,
  output logic                    ad_out,
  output logic                    nl_out,
  output logic                    nf_out,
  output logic [FC_WIDTH-1:0]     fc_out
);

  // 32-bit timing landmarks so comparisons never truncate at counter width
  localparam int TOTAL_H  = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int TOTAL_V  = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
  localparam int HS_START = ACTIVE_H_PIXELS + H_FRONT_PORCH;
  localparam int HS_END   = HS_START + H_SYNC_WIDTH;
  localparam int VS_START = ACTIVE_LINES + V_FRONT_PORCH;
  localparam int VS_END   = VS_START + V_SYNC_WIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [HCOUNT_WIDTH-1:0] h_d;
  logic [VCOUNT_WIDTH-1:0] v_d;
  logic [FC_WIDTH-1:0]     fc_d;
  logic                    hs_d, vs_d, ad_d, nl_d, nf_d;
  logic                    load;

  // Next position, then decode of every output from that next position
  always_comb begin
    state_d = state_q;
    h_d     = hcount_out;
    v_d     = vcount_out;
    fc_d    = fc_out;
    hs_d    = hs_out;
    vs_d    = vs_out;
    ad_d    = ad_out;
    nl_d    = 1'b0;
    nf_d    = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        // first enabled edge presents (0,0) without advancing
        if (en_in) begin
          state_d = RUN;
          h_d     = '0;
          v_d     = '0;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (en_in) begin
          load = 1'b1;
          if (32'(hcount_out) == TOTAL_H - 1) begin
            h_d = '0;
            if (32'(vcount_out) == TOTAL_V - 1) v_d = '0;
            else                               v_d = vcount_out + VCOUNT_WIDTH'(1);
          end else begin
            h_d = hcount_out + HCOUNT_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      ad_d = (32'(h_d) < ACTIVE_H_PIXELS) && (32'(v_d) < ACTIVE_LINES);
      hs_d = ((32'(h_d) >= HS_START) && (32'(h_d) < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
      vs_d = ((32'(v_d) >= VS_START) && (32'(v_d) < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
      nl_d = (32'(h_d) == 0);
      nf_d = (32'(h_d) == ACTIVE_H_PIXELS) && (32'(v_d) == ACTIVE_LINES);
      if (nf_d)
        fc_d = (32'(fc_out) >= FC_MAX - 1) ? '0 : fc_out + FC_WIDTH'(1);
    end
  end

  // State and output registers; reset forces the idle presentation
  always_ff @(posedge clk_pixel_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      hcount_out <= '0;
      vcount_out <= '0;
      fc_out     <= '0;
      hs_out     <= ~H_SYNC_POL;
      vs_out     <= ~V_SYNC_POL;
      ad_out     <= 1'b0;
      nl_out     <= 1'b0;
      nf_out     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcount_out <= h_d;
      vcount_out <= v_d;
      fc_out     <= fc_d;
      hs_out     <= hs_d;
      vs_out     <= vs_d;
      ad_out     <= ad_d;
      nl_out     <= nl_d;
      nf_out     <= nf_d;
    end
  end

endmodule

// File: tb/tb_video_sig_gen_cfg.sv
// Bench for video_sig_gen_cfg: small timing, two instances (hsync active-high
// and active-low), compared each cycle against a linear-pixel-index model.
module tb_video_sig_gen_cfg;

  localparam int AH = 30, HFP = 11, HSW = 4, HBP = 22;
  localparam int AV = 10, VFP = 5, VSW = 5, VBP = 2;
  localparam int TH = AH + HFP + HSW + HBP;   // 67
  localparam int TV = AV + VFP + VSW + VBP;   // 22
  localparam int FCM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [10:0] hc_a, hc_b;
  logic [9:0]  vc_a, vc_b;
  logic        hs_a, vs_a, ad_a, nl_a, nf_a;
  logic        hs_b, vs_b, ad_b, nl_b, nf_b;
  logic [5:0]  fc_a, fc_b;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // reference model: linear pixel index within the frame
  bit m_started;
  int m_p, m_fc;
  bit m_nl, m_nf;

  always #5 clk = ~clk;

  video_sig_gen_cfg #(
    .ACTIVE_H_PIXELS(AH), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP),
    .ACTIVE_LINES(AV), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .FC_MAX(FCM)
  ) dut (
    .clk_pixel_in(clk), .rst_in(rst_n), .en_in(en),
    .hcount_out(hc_a), .vcount_out(vc_a), .hs_out(hs_a), .vs_out(vs_a),
    .ad_out(ad_a), .nl_out(nl_a), .nf_out(nf_a), .fc_out(fc_a)
  );

  video_sig_gen_cfg #(
    .ACTIVE_H_PIXELS(AH), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP),
    .ACTIVE_LINES(AV), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1), .FC_MAX(FCM)
  ) dut_n (
    .clk_pixel_in(clk), .rst_in(rst_n), .en_in(en),
    .hcount_out(hc_b), .vcount_out(vc_b), .hs_out(hs_b), .vs_out(vs_b),
    .ad_out(ad_b), .nl_out(nl_b), .nf_out(nf_b), .fc_out(fc_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_n, obs, exp);
    end
  endtask

  function automatic int mh();
    return m_started ? m_p % TH : 0;
  endfunction

  function automatic int mv();
    return m_started ? m_p / TH : 0;
  endfunction

  function automatic bit m_hs(input bit pol);
    if (!m_started) return !pol;
    return (mh() >= AH + HFP && mh() < AH + HFP + HSW) ? pol : !pol;
  endfunction

  function automatic bit m_vs();
    if (!m_started) return 1'b0;
    return (mv() >= AV + VFP && mv() < AV + VFP + VSW);
  endfunction

  task automatic model_step(input bit r, input bit e);
    if (!r) begin
      m_started = 0; m_p = 0; m_fc = 0; m_nl = 0; m_nf = 0;
    end else if (e) begin
      if (!m_started) begin m_started = 1; m_p = 0; end
      else m_p = (m_p + 1) % (TH * TV);
      m_nl = (mh() == 0);
      m_nf = (mh() == AH) && (mv() == AV);
      if (m_nf) m_fc = (m_fc + 1) % FCM;
    end else begin
      m_nl = 0; m_nf = 0;
    end
  endtask

  task automatic check_all();
    chk("hcount", 32'(hc_a), 32'(mh()));
    chk("vcount", 32'(vc_a), 32'(mv()));
    chk("ad",     32'(ad_a), 32'(m_started && mh() < AH && mv() < AV));
    chk("hs",     32'(hs_a), 32'(m_hs(1'b1)));
    chk("vs",     32'(vs_a), 32'(m_vs()));
    chk("nl",     32'(nl_a), 32'(m_nl));
    chk("nf",     32'(nf_a), 32'(m_nf));
    chk("fc",     32'(fc_a), 32'(m_fc));
    chk("hs_neg", 32'(hs_b), 32'(m_hs(1'b0)));
    chk("hc_neg", 32'(hc_b), 32'(mh()));
    chk("nf_neg", 32'(nf_b), 32'(m_nf));
  endtask

  // one clock: drive at negedge, model on the edge, sample 1 time unit later
  task automatic cyc(input bit r, input bit e);
    rst_n = r;
    en    = e;
    @(posedge clk);
    model_step(r, e);
    cyc_n++;
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic run_to(input int h, input int v, input int budget);
    int n = 0;
    while (!(m_started && mh() == h && mv() == v) && n < budget) begin
      cyc(1, 1);
      n++;
    end
    chk("reach", 32'(m_started && mh() == h && mv() == v), 32'd1);
  endtask

  initial begin
    int t0, n;
    bit seen;
    @(negedge clk);
    // 1: reset then release
    repeat (3) cyc(0, 1);
    chk("t1_rst_hs", 32'(hs_a), 32'd0);
    chk("t1_rst_ad", 32'(ad_a), 32'd0);
    cyc(1, 1);
    chk("t1_start_nl", 32'(nl_a), 32'd1);
    chk("t1_start_ad", 32'(ad_a), 32'd1);
    cyc(1, 1);
    chk("t1_h1", 32'(hc_a), 32'd1);
    chk("t1_nl0", 32'(nl_a), 32'd0);
    // 2: one line
    run_to(TH - 1, 0, 200);
    cyc(1, 1);
    chk("t2_wrap_v", 32'(vc_a), 32'd1);
    chk("t2_wrap_nl", 32'(nl_a), 32'd1);
    // 3: frame period between nf pulses
    run_to(AH, AV, 3000);
    t0 = cyc_n;
    n = 0; seen = 0;
    while (!seen && n < 3000) begin
      cyc(1, 1); n++;
      seen = nf_a;
    end
    chk("t3_period", 32'(cyc_n - t0), 32'd1474);
    // 4: several frames through the fc wrap
    repeat (5 * TH * TV) cyc(1, 1);
    // 5: stall on the nf position and on the frame-wrap position
    run_to(AH, AV, 3000);
    chk("t5_nf_first", 32'(nf_a), 32'd1);
    repeat (5) cyc(1, 0);
    chk("t5_nf_held_low", 32'(nf_a), 32'd0);
    run_to(TH - 1, TV - 1, 3000);
    repeat (3) cyc(1, 0);
    cyc(1, 1);
    chk("t5_wrap", 32'({hc_a, vc_a}), 32'd0);
    // 6: mid-frame reset
    run_to(20, 12, 3000);
    cyc(0, 1);
    chk("t6_rst_h", 32'(hc_a), 32'd0);
    chk("t6_rst_hsn", 32'(hs_b), 32'd1);
    cyc(1, 0);
    cyc(1, 1);
    // random enables and occasional resets
    repeat (6000) cyc($urandom_range(0, 399) != 0, $urandom_range(0, 9) != 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_sig_gen_cfg.md
Name: video_sig_gen_cfg

Overview:
- Parametrised successor to the fixed-polarity video timing generator. Produces pixel/line counters, H/V sync, active-draw, new-frame pulse and a wrapping frame counter.
- Adds programmable sync polarity, a pixel-enable (stall) input, a new-line pulse, a configurable frame-counter modulus and an explicit post-reset start state.
- Sits at the head of the pixel pipeline and drives the sprite/TMDS path. Default timing is 1280x720@60.

Parameters:
ACTIVE_H_PIXELS, 1280, active pixels per line
H_FRONT_PORCH, 110, pixels from end of active to hsync start
H_SYNC_WIDTH, 40, hsync width in pixels
H_BACK_PORCH, 220, pixels from hsync end to line end
ACTIVE_LINES, 720, active lines per frame
V_FRONT_PORCH, 5, lines from end of active to vsync start
V_SYNC_WIDTH, 5, vsync width in lines
V_BACK_PORCH, 20, lines from vsync end to frame end
H_SYNC_POL, 1, 1 = hs_out active-high, 0 = active-low
V_SYNC_POL, 1, 1 = vs_out active-high, 0 = active-low
HCOUNT_WIDTH, 11, hcount_out width; must hold TOTAL_H-1
VCOUNT_WIDTH, 10, vcount_out width; must hold TOTAL_V-1
FC_WIDTH, 6, fc_out width
FC_MAX, 60, frame-counter modulus; fc_out counts 0..FC_MAX-1; must satisfy FC_MAX <= 2^FC_WIDTH

Ports:
clk_pixel_in  input  1  pixel clock
rst_in  input  1  synchronous, active-low reset (0 = reset)
en_in  input  1  pixel enable; 0 stalls the generator
hcount_out  output  HCOUNT_WIDTH  pixel index in line
vcount_out  output  VCOUNT_WIDTH  line index in frame
hs_out  output  1  horizontal sync, polarity set by H_SYNC_POL
vs_out  output  1  vertical sync, polarity set by V_SYNC_POL
ad_out  output  1  active draw
nl_out  output  1  one-cycle pulse at the start of each line
nf_out  output  1  one-cycle pulse at the start of vertical blanking
fc_out  output  FC_WIDTH  frame count

Behaviour:
- Definitions:
  - TOTAL_H = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH.
  - TOTAL_V = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH.
- Outputs: all registered; no combinational path from en_in to any output.
- States:
  - IDLE: entered on any clock edge with rst_in=0, including mid-frame. Outputs: hcount=0, vcount=0, ad=0, nl=0, nf=0, fc=0, hs=~H_SYNC_POL, vs=~V_SYNC_POL.
  - IDLE -> RUN: first edge with rst_in=1 and en_in=1. Presents position (0,0) with ad=1, nl=1. Counters do not advance on this edge.
  - RUN, en_in=1: hcount increments. At TOTAL_H-1, hcount wraps to 0 and vcount increments. At (TOTAL_H-1, TOTAL_V-1), both counters wrap to 0.
  - RUN, en_in=0: counters, hs, vs, ad and fc hold. nl and nf are forced to 0, so a pulse is never stretched or repeated.
- Output decode: each output reflects the registered position on the same cycle.
  - ad = (hcount < ACTIVE_H_PIXELS) && (vcount < ACTIVE_LINES).
  - hs = H_SYNC_POL when ACTIVE_H_PIXELS+H_FRONT_PORCH <= hcount < ACTIVE_H_PIXELS+H_FRONT_PORCH+H_SYNC_WIDTH; otherwise ~H_SYNC_POL.
  - vs = V_SYNC_POL for all pixels of lines ACTIVE_LINES+V_FRONT_PORCH <= vcount < ACTIVE_LINES+V_FRONT_PORCH+V_SYNC_WIDTH; otherwise ~V_SYNC_POL.
  - nl = 1 on the enabled cycle presenting hcount=0.
  - nf = 1 on the enabled cycle presenting hcount=ACTIVE_H_PIXELS and vcount=ACTIVE_LINES.
- Frame counter: fc increments on the same edge that asserts nf. It wraps FC_MAX-1 -> 0.
- Width rule: comparisons use TOTAL_H/TOTAL_V computed as 32-bit integers, so there is no truncation at counter width.
- Simultaneous events:
  - Reset dominates en_in.
  - A stall landing on the wrap cycle holds (TOTAL_H-1, TOTAL_V-1) until en_in returns.

Test Plan (bench timing: 30/11/4/22 horizontal, 10/5/5/2 vertical, TOTAL_H=67, TOTAL_V=22, FC_MAX=4, pols=1):
1. Reset held 3 cycles, then released with en_in=1 -> during reset: hcount=0, ad=0, hs=0, vs=0. First edge after release: (0,0), ad=1, nl=1. Next edge: hcount=1, nl=0.
2. Free run for one line -> ad=1 for hcount 0..29; hs=1 exactly for hcount 41..44; at hcount 66 the next edge gives hcount=0, vcount=1, nl=1.
3. Free run for one frame -> vs=1 for all of vcount 15..19; nf=1 for exactly one cycle at (30,10); fc goes 0->1 on that edge; frame period is 1474 cycles.
4. Five frames with FC_MAX=4 -> fc sequence 1, 2, 3, 0, 1.
5. en_in=0 for 5 cycles while at (30,10), plus a separate stall at (66,21) -> all outputs hold; nf is high only on the first presentation of (30,10); the wrap to (0,0) occurs on the first enabled edge after the stall.
6. rst_in=0 at (20,12) mid-frame; also a rerun of test 2 with H_SYNC_POL=0 -> after reset, outputs return to IDLE values; hs is inverted (0 only for hcount 41..44).
